// File: rtl/axi_line_mem_pkg.sv
// Shared types and width helpers for the line-granular AXI memory responder.
package axi_line_mem_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_e;

    // Widths for the default geometry (64-byte lines, 1024 lines).
    localparam int unsigned DEF_LINE_SIZE   = 64;
    localparam int unsigned DEF_DEPTH_LINES = 1024;
    localparam int unsigned DEF_OFFSET_W    = $clog2(DEF_LINE_SIZE);
    localparam int unsigned DEF_INDEX_W     = $clog2(DEF_DEPTH_LINES);

    // Bits needed to hold a latency countdown that starts at lat-1.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat <= 1) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/line_mem_array.sv
// Line store: one byte-enabled synchronous write port, one synchronous read port.
// A read and a write to the same line on the same edge returns the old contents.
module line_mem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned BYTES = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [IDX_W-1:0]   i_waddr,
    input  logic [BYTES*8-1:0] i_wdata,
    input  logic [BYTES-1:0]   i_wstrb,
    input  logic               i_re,
    input  logic [IDX_W-1:0]   i_raddr,
    output logic [BYTES*8-1:0] o_rdata
);

    logic [BYTES*8-1:0] r_mem [DEPTH];
    logic [BYTES*8-1:0] r_rdata;

    // Byte-lane write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read output register: loads only on a sample so it holds through the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_line_mem_responder.sv
// Single-beat AXI-style slave backed by a line store; independent read and write FSMs
// with configurable response latencies.
module axi_line_mem_responder
    import axi_line_mem_pkg::*;
#(
    parameter int unsigned LINE_SIZE     = 64,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DEPTH_LINES   = 1024,
    parameter int unsigned READ_LATENCY  = 3,
    parameter int unsigned WRITE_LATENCY = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   axi_awvalid,
    output logic                   axi_awready,
    input  logic [ADDR_WIDTH-1:0]  axi_awaddr,
    input  logic                   axi_wvalid,
    output logic                   axi_wready,
    input  logic [LINE_SIZE*8-1:0] axi_wdata,
    input  logic [LINE_SIZE-1:0]   axi_wstrb,
    input  logic                   axi_wlast,
    output logic                   axi_bvalid,
    input  logic                   axi_bready,
    input  logic                   axi_arvalid,
    output logic                   axi_arready,
    input  logic [ADDR_WIDTH-1:0]  axi_araddr,
    output logic                   axi_rvalid,
    input  logic                   axi_rready,
    output logic [LINE_SIZE*8-1:0] axi_rdata
);

    localparam int unsigned OFF_W  = $clog2(LINE_SIZE);
    localparam int unsigned IDX_W  = $clog2(DEPTH_LINES);
    localparam int unsigned DATA_W = LINE_SIZE * 8;
    localparam int unsigned WCNT_W = cnt_width(WRITE_LATENCY);
    localparam int unsigned RCNT_W = cnt_width(READ_LATENCY);

    // Offset and upper address bits do not select a line; wlast carries no information.
    logic w_unused;
    assign w_unused = ^{axi_awaddr[OFF_W-1:0], axi_awaddr[ADDR_WIDTH-1:OFF_W+IDX_W],
                        axi_araddr[OFF_W-1:0], axi_araddr[ADDR_WIDTH-1:OFF_W+IDX_W],
                        axi_wlast};

    // Write side state
    w_state_e            r_wr_state, w_wr_state_d;
    logic [WCNT_W-1:0]   r_wr_cnt, w_wr_cnt_d;
    logic                r_aw_full, w_aw_full_d;
    logic                r_w_full, w_w_full_d;
    logic [IDX_W-1:0]    r_aw_idx, w_aw_idx_d;
    logic [DATA_W-1:0]   r_wdata, w_wdata_d;
    logic [LINE_SIZE-1:0] r_wstrb, w_wstrb_d;
    logic                r_awready, w_awready_d;
    logic                r_wready, w_wready_d;
    logic                r_bvalid, w_bvalid_d;
    logic                w_commit;

    // Read side state
    r_state_e            r_rd_state, w_rd_state_d;
    logic [RCNT_W-1:0]   r_rd_cnt, w_rd_cnt_d;
    logic [IDX_W-1:0]    r_ar_idx, w_ar_idx_d;
    logic                r_arready, w_arready_d;
    logic                r_rvalid, w_rvalid_d;
    logic                w_rd_sample;

    // Write FSM next state: buffer AW/W independently, commit once both are held.
    always_comb begin
        w_wr_state_d = r_wr_state;
        w_wr_cnt_d   = r_wr_cnt;
        w_aw_full_d  = r_aw_full;
        w_w_full_d   = r_w_full;
        w_aw_idx_d   = r_aw_idx;
        w_wdata_d    = r_wdata;
        w_wstrb_d    = r_wstrb;
        w_commit     = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (axi_awvalid && r_awready) begin
                    w_aw_full_d = 1'b1;
                    w_aw_idx_d  = axi_awaddr[OFF_W +: IDX_W];
                end
                if (axi_wvalid && r_wready) begin
                    w_w_full_d = 1'b1;
                    w_wdata_d  = axi_wdata;
                    w_wstrb_d  = axi_wstrb;
                end
                // Both readies are low when both buffers are full, so no new beat collides.
                if (r_aw_full && r_w_full) begin
                    w_commit     = 1'b1;
                    w_aw_full_d  = 1'b0;
                    w_w_full_d   = 1'b0;
                    w_wr_cnt_d   = WCNT_W'(WRITE_LATENCY - 1);
                    w_wr_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (r_wr_cnt == '0) begin
                    w_wr_state_d = W_RESP;
                end else begin
                    w_wr_cnt_d = r_wr_cnt - WCNT_W'(1);
                end
            end
            W_RESP: begin
                if (r_bvalid && axi_bready) begin
                    w_wr_state_d = W_IDLE;
                end
            end
            default: begin
                w_wr_state_d = W_IDLE;
            end
        endcase
        w_awready_d = (w_wr_state_d == W_IDLE) && !w_aw_full_d;
        w_wready_d  = (w_wr_state_d == W_IDLE) && !w_w_full_d;
        w_bvalid_d  = (w_wr_state_d == W_RESP);
    end

    // Write FSM registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_wr_cnt   <= '0;
            r_aw_full  <= 1'b0;
            r_w_full   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_d;
            r_wr_cnt   <= w_wr_cnt_d;
            r_aw_full  <= w_aw_full_d;
            r_w_full   <= w_w_full_d;
            r_aw_idx   <= w_aw_idx_d;
            r_wdata    <= w_wdata_d;
            r_wstrb    <= w_wstrb_d;
            r_awready  <= w_awready_d;
            r_wready   <= w_wready_d;
            r_bvalid   <= w_bvalid_d;
        end
    end

    // Read FSM next state: count down, then sample the store once into the rdata register.
    always_comb begin
        w_rd_state_d = r_rd_state;
        w_rd_cnt_d   = r_rd_cnt;
        w_ar_idx_d   = r_ar_idx;
        w_rd_sample  = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (axi_arvalid && r_arready) begin
                    w_ar_idx_d   = axi_araddr[OFF_W +: IDX_W];
                    w_rd_cnt_d   = RCNT_W'(READ_LATENCY - 1);
                    w_rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_rd_cnt == '0) begin
                    w_rd_sample  = 1'b1;
                    w_rd_state_d = R_RESP;
                end else begin
                    w_rd_cnt_d = r_rd_cnt - RCNT_W'(1);
                end
            end
            R_RESP: begin
                if (r_rvalid && axi_rready) begin
                    w_rd_state_d = R_IDLE;
                end
            end
            default: begin
                w_rd_state_d = R_IDLE;
            end
        endcase
        w_arready_d = (w_rd_state_d == R_IDLE);
        w_rvalid_d  = (w_rd_state_d == R_RESP);
    end

    // Read FSM registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rd_cnt   <= '0;
            r_ar_idx   <= '0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_d;
            r_rd_cnt   <= w_rd_cnt_d;
            r_ar_idx   <= w_ar_idx_d;
            r_arready  <= w_arready_d;
            r_rvalid   <= w_rvalid_d;
        end
    end

    line_mem_array #(
        .DEPTH (DEPTH_LINES),
        .BYTES (LINE_SIZE),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_commit),
        .i_waddr (r_aw_idx),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_re    (w_rd_sample),
        .i_raddr (r_ar_idx),
        .o_rdata (axi_rdata)
    );

    assign axi_awready = r_awready;
    assign axi_wready  = r_wready;
    assign axi_bvalid  = r_bvalid;
    assign axi_arready = r_arready;
    assign axi_rvalid  = r_rvalid;

endmodule

// File: tb/tb_axi_line_mem_responder.sv
// Bench for axi_line_mem_responder: directed table, multi-cycle corner sequences and
// randomized traffic checked against a byte-level reference store.
module tb_axi_line_mem_responder;

    localparam int LS = 64;
    localparam int AW = 32;
    localparam int DL = 1024;
    localparam int RL = 3;
    localparam int WL = 3;
    localparam int DW = LS * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          axi_awvalid, axi_awready;
    logic [AW-1:0] axi_awaddr;
    logic          axi_wvalid, axi_wready;
    logic [DW-1:0] axi_wdata;
    logic [LS-1:0] axi_wstrb;
    logic          axi_wlast;
    logic          axi_bvalid, axi_bready;
    logic          axi_arvalid, axi_arready;
    logic [AW-1:0] axi_araddr;
    logic          axi_rvalid, axi_rready;
    logic [DW-1:0] axi_rdata;

    always #5 clk = ~clk;

    axi_line_mem_responder #(
        .LINE_SIZE     (LS),
        .ADDR_WIDTH    (AW),
        .DEPTH_LINES   (DL),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_awaddr  (axi_awaddr),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_araddr  (axi_araddr),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_rdata   (axi_rdata)
    );

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [LS-1:0] strb;
        logic [DW-1:0] exp;
    } vec_t;

    logic [DW-1:0] ref_mem [DL];
    int n_total = 0;
    int n_bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'((a / LS) % DL);
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [LS-1:0] s);
        for (int b = 0; b < LS; b++) begin
            if (s[b]) ref_mem[idx_of(a)][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Simultaneous AW+W, then wait for B with bready high. lat = edges from AW/W to bvalid.
    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LS-1:0] s,
                      output int lat);
        int g;
        axi_awaddr  = a;
        axi_wdata   = d;
        axi_wstrb   = s;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        g = 0;
        while (!(axi_awready && axi_wready) && g < 50) begin
            tick();
            g++;
        end
        chk("wr_ready", DW'({axi_awready, axi_wready}), DW'(2'b11));
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        ref_write(a, d, s);
        lat = -1;
        g   = 0;
        while (lat < 0 && g < 50) begin
            tick();
            g++;
            if (axi_bvalid) lat = g;
        end
        tick();
    endtask

    // AR, then wait for R with rready high. lat = edges from AR to rvalid.
    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        int g;
        axi_araddr  = a;
        axi_arvalid = 1'b1;
        g = 0;
        while (!axi_arready && g < 50) begin
            tick();
            g++;
        end
        chk("rd_ready", DW'(axi_arready), DW'(1));
        tick();
        axi_arvalid = 1'b0;
        lat = -1;
        g   = 0;
        while (lat < 0 && g < 50) begin
            tick();
            g++;
            if (axi_rvalid) lat = g;
        end
        d = axi_rdata;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        vec_t          tbl [8];
        logic [DW-1:0] inc, mix, d, d4, d5, held;
        logic [LS-1:0] s;
        logic [AW-1:0] a;
        int            lat, g;

        axi_awvalid = 1'b0;
        axi_awaddr  = '0;
        axi_wvalid  = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wlast   = 1'b1;
        axi_bready  = 1'b1;
        axi_arvalid = 1'b0;
        axi_araddr  = '0;
        axi_rready  = 1'b1;
        for (int i = 0; i < DL; i++) ref_mem[i] = '0;

        // Reset values, then readies rise on the first edge after release.
        #2 rst = 1'b1;
        #1;
        chk("rst_ctl", DW'({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid}),
            DW'(0));
        chk("rst_rdata", axi_rdata, DW'(0));
        tick();
        tick();
        chk("rst_ctl_held", DW'({axi_awready, axi_wready, axi_arready}), DW'(0));
        rst = 1'b0;
        chk("pre_edge_arready", DW'(axi_arready), DW'(0));
        tick();
        chk("post_rst_ready", DW'({axi_awready, axi_wready, axi_arready}), DW'(3'b111));

        // Directed table with hand-derived expected read data.
        for (int b = 0; b < LS; b++) inc[b*8 +: 8] = 8'(b);
        mix = {LS{8'hAA}};
        mix[31:0] = 32'h1111_1111;
        tbl[0] = '{1'b1, 32'h0000_1000, inc,            {LS{1'b1}}, '0};
        tbl[1] = '{1'b0, 32'h0000_1000, '0,             '0,         inc};
        tbl[2] = '{1'b1, 32'h0000_2000, {LS{8'hAA}},    {LS{1'b1}}, '0};
        tbl[3] = '{1'b1, 32'h0000_2000, {LS{8'h11}},    LS'(4'hF),  '0};
        tbl[4] = '{1'b0, 32'h0000_2000, '0,             '0,         mix};
        tbl[5] = '{1'b1, 32'h0000_3000, {LS{8'h55}},    {LS{1'b1}}, '0};
        tbl[6] = '{1'b0, 32'h0001_3000, '0,             '0,         {LS{8'h55}}};
        tbl[7] = '{1'b0, 32'h0000_103F, '0,             '0,         inc};
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].is_wr) begin
                wr(tbl[i].addr, tbl[i].data, tbl[i].strb, lat);
                chk($sformatf("tbl%0d_b_lat", i), DW'(lat), DW'(WL + 1));
            end else begin
                rd(tbl[i].addr, d, lat);
                chk($sformatf("tbl%0d_r_lat", i), DW'(lat), DW'(RL));
                chk($sformatf("tbl%0d_data", i), d, tbl[i].exp);
            end
        end

        // AW five cycles ahead of W: nothing commits until W arrives.
        d = rand_line();
        axi_awaddr  = 32'h0000_7000;
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("awfirst_hold", DW'({axi_bvalid, axi_awready, axi_wready}), DW'(3'b001));
            tick();
        end
        axi_wdata  = d;
        axi_wstrb  = {LS{1'b1}};
        axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        ref_write(32'h0000_7000, d, {LS{1'b1}});
        lat = -1;
        g   = 0;
        while (lat < 0 && g < 50) begin
            tick();
            g++;
            if (axi_bvalid) lat = g;
        end
        chk("awfirst_b_lat", DW'(lat), DW'(WL + 1));
        tick();
        rd(32'h0000_7000, held, lat);
        chk("awfirst_data", held, d);

        // W five cycles ahead of AW.
        d = rand_line();
        axi_wdata  = d;
        axi_wstrb  = {LS{1'b1}};
        axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("wfirst_hold", DW'({axi_bvalid, axi_awready, axi_wready}), DW'(3'b010));
            tick();
        end
        axi_awaddr  = 32'h0000_7040;
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        ref_write(32'h0000_7040, d, {LS{1'b1}});
        lat = -1;
        g   = 0;
        while (lat < 0 && g < 50) begin
            tick();
            g++;
            if (axi_bvalid) lat = g;
        end
        chk("wfirst_b_lat", DW'(lat), DW'(WL + 1));
        tick();
        rd(32'h0000_7040, held, lat);
        chk("wfirst_data", held, d);

        // Backpressure on both response channels for 10 cycles.
        d = rand_line();
        axi_bready  = 1'b0;
        axi_rready  = 1'b0;
        axi_awaddr  = 32'h0000_6000;
        axi_wdata   = d;
        axi_wstrb   = {LS{1'b1}};
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        axi_araddr  = 32'h0000_1000;
        axi_arvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_arvalid = 1'b0;
        ref_write(32'h0000_6000, d, {LS{1'b1}});
        g = 0;
        while (!(axi_bvalid && axi_rvalid) && g < 20) begin
            tick();
            g++;
        end
        for (int k = 0; k < 10; k++) begin
            chk("stall_ctl",
                DW'({axi_bvalid, axi_rvalid, axi_awready, axi_wready, axi_arready}),
                DW'(5'b11000));
            chk("stall_rdata", axi_rdata, inc);
            tick();
        end
        axi_bready = 1'b1;
        axi_rready = 1'b1;
        tick();
        chk("release_ctl",
            DW'({axi_bvalid, axi_rvalid, axi_awready, axi_wready, axi_arready}),
            DW'(5'b00111));
        rd(32'h0000_6000, held, lat);
        chk("stall_wr_data", held, d);

        // Read sample and write commit to line 0x3000 on the same edge.
        chk("coll_ready", DW'({axi_awready, axi_wready, axi_arready}), DW'(3'b111));
        axi_araddr  = 32'h0000_3000;
        axi_arvalid = 1'b1;
        tick();
        axi_arvalid = 1'b0;
        tick();
        axi_awaddr  = 32'h0000_3000;
        axi_wdata   = {LS{8'h77}};
        axi_wstrb   = {LS{1'b1}};
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        tick();
        chk("coll_rvalid", DW'(axi_rvalid), DW'(1));
        chk("coll_old", axi_rdata, {LS{8'h55}});
        tick();
        g = 0;
        while (!axi_bvalid && g < 50) begin
            tick();
            g++;
        end
        chk("coll_bvalid", DW'(axi_bvalid), DW'(1));
        tick();
        ref_write(32'h0000_3000, {LS{8'h77}}, {LS{1'b1}});
        rd(32'h0000_3000, held, lat);
        chk("coll_new", held, {LS{8'h77}});

        // Randomized traffic over 16 lines with aliasing upper and offset address bits.
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            a[15:6] = 10'(512 + i);
            wr(a, rand_line(), {LS{1'b1}}, lat);
        end
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            a[15:6] = 10'(512 + $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                d = rand_line();
                s = {$urandom, $urandom};
                wr(a, d, s, lat);
                chk("rnd_b_lat", DW'(lat), DW'(WL + 1));
            end else begin
                rd(a, d, lat);
                chk("rnd_r_lat", DW'(lat), DW'(RL));
                chk("rnd_data", d, ref_mem[idx_of(a)]);
            end
        end

        // Reset while both FSMs are counting down.
        d4 = rand_line();
        d5 = rand_line();
        wr(32'h0000_4000, d4, {LS{1'b1}}, lat);
        axi_awaddr  = 32'h0000_5000;
        axi_wdata   = d5;
        axi_wstrb   = {LS{1'b1}};
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        axi_araddr  = 32'h0000_4000;
        axi_arvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_arvalid = 1'b0;
        tick();
        ref_write(32'h0000_5000, d5, {LS{1'b1}});
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_ctl", DW'({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid}),
            DW'(0));
        chk("midrst_rdata", axi_rdata, DW'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_ready", DW'({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid}),
            DW'(5'b11100));
        rd(32'h0000_4000, held, lat);
        chk("midrst_keep4000", held, d4);
        rd(32'h0000_5000, held, lat);
        chk("midrst_keep5000", held, d5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
